// File: rtl/otter_pkg.sv
// Shared types for the OTTER multicycle control unit: opcodes, FSM states, trap causes
// and the wait-timer width helper.
package otter_pkg;

    typedef enum logic [6:0] {
        OpLui    = 7'b0110111,
        OpAuipc  = 7'b0010111,
        OpJal    = 7'b1101111,
        OpJalr   = 7'b1100111,
        OpBranch = 7'b1100011,
        OpLoad   = 7'b0000011,
        OpStore  = 7'b0100011,
        OpImm    = 7'b0010011,
        OpRg3    = 7'b0110011,
        OpSys    = 7'b1110011
    } opcode_t;

    typedef enum logic [2:0] {
        StInit, StFetch, StExec, StLdWait, StStWait, StWb, StIntr, StTrap
    } cu_state_t;

    typedef enum logic [1:0] {
        CauseNone    = 2'b00,
        CauseIllegal = 2'b01,
        CauseTimeout = 2'b10
    } trap_cause_t;

    function automatic int unsigned wait_cnt_width(int unsigned max_wait);
        int unsigned w;
        w = $clog2(max_wait + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/otter_wait_timer.sv
// Saturating wait counter for memory handshakes; flags timeout once MAX_WAIT-1 cycles
// have elapsed without ready. MAX_WAIT = 0 disables the timeout.
module otter_wait_timer
    import otter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam int unsigned W = wait_cnt_width(MAX_WAIT);
    localparam logic [W-1:0] Limit = (MAX_WAIT == 0) ? '0 : W'(MAX_WAIT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign timeout = (MAX_WAIT != 0) && (cnt_q >= Limit);

endmodule

// File: rtl/otter_cu_fsm_mc.sv
// Multicycle control unit for the OTTER: fetch/execute/writeback sequencing with ready
// handshakes, bounded memory waits, illegal-opcode/timeout traps and masked interrupts.
module otter_cu_fsm_mc
    import otter_pkg::*;
#(
    parameter int unsigned MAX_WAIT     = 15,
    parameter bit          INTR_EN      = 1'b1,
    parameter bit          TRAP_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       intr,
    input  logic       mie,
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic       mem_rdy1,
    input  logic       mem_rdy2,
    output logic       PC_WE,
    output logic       RF_WE,
    output logic       memRDEN1,
    output logic       memRDEN2,
    output logic       memWE2,
    output logic       csr_WE,
    output logic       reset,
    output logic       intr_taken,
    output logic       mret_exec,
    output logic       trap_taken,
    output logic [1:0] trap_cause,
    output logic [2:0] state
);

    cu_state_t   ps_q, ps_d;
    trap_cause_t cause_q, cause_d;
    logic        tmr_clr, tmr_en, timeout, complete;

    otter_wait_timer #(
        .MAX_WAIT(MAX_WAIT)
    ) u_wait_timer (
        .clk    (clk),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .timeout(timeout)
    );

    // The EXEC cycle that issues a load/store is the first cycle of that request's wait
    // budget, so the counter keeps running across EXEC -> LD_WAIT/ST_WAIT.
    assign tmr_clr = RST || ((ps_d != ps_q) &&
                     !((ps_q == StExec) && (ps_d inside {StLdWait, StStWait})));

    always_comb begin
        ps_d       = ps_q;
        cause_d    = cause_q;
        tmr_en     = 1'b0;
        complete   = 1'b0;
        PC_WE      = 1'b0;
        RF_WE      = 1'b0;
        memRDEN1   = 1'b0;
        memRDEN2   = 1'b0;
        memWE2     = 1'b0;
        csr_WE     = 1'b0;
        reset      = 1'b0;
        intr_taken = 1'b0;
        mret_exec  = 1'b0;
        trap_taken = 1'b0;
        trap_cause = CauseNone;

        case (ps_q)
            StInit: begin
                reset = 1'b1;
                ps_d  = StFetch;
            end
            StFetch: begin
                memRDEN1 = 1'b1;
                if (mem_rdy1) begin
                    ps_d = StExec;
                end else begin
                    tmr_en = 1'b1;
                    if (timeout) begin
                        ps_d    = StTrap;
                        cause_d = CauseTimeout;
                    end
                end
            end
            StExec: begin
                case (opcode)
                    OpImm, OpRg3, OpLui, OpAuipc, OpJal, OpJalr: begin
                        RF_WE    = 1'b1;
                        PC_WE    = 1'b1;
                        complete = 1'b1;
                    end
                    OpBranch: begin
                        PC_WE    = 1'b1;
                        complete = 1'b1;
                    end
                    OpLoad: begin
                        memRDEN2 = 1'b1;
                        tmr_en   = 1'b1;
                        ps_d     = StLdWait;
                    end
                    OpStore: begin
                        memWE2 = 1'b1;
                        if (mem_rdy2) begin
                            PC_WE    = 1'b1;
                            complete = 1'b1;
                        end else begin
                            tmr_en = 1'b1;
                            ps_d   = StStWait;
                        end
                    end
                    OpSys: begin
                        if (func3 == 3'b000) begin
                            mret_exec = 1'b1;
                        end else begin
                            csr_WE = 1'b1;
                            RF_WE  = 1'b1;
                        end
                        PC_WE    = 1'b1;
                        complete = 1'b1;
                    end
                    default: begin
                        if (TRAP_ILLEGAL) begin
                            ps_d    = StTrap;
                            cause_d = CauseIllegal;
                        end else begin
                            PC_WE    = 1'b1;
                            complete = 1'b1;
                        end
                    end
                endcase
            end
            StLdWait: begin
                memRDEN2 = 1'b1;
                if (mem_rdy2) begin
                    ps_d = StWb;
                end else begin
                    tmr_en = 1'b1;
                    if (timeout) begin
                        ps_d    = StTrap;
                        cause_d = CauseTimeout;
                    end
                end
            end
            StStWait: begin
                memWE2 = 1'b1;
                if (mem_rdy2) begin
                    PC_WE    = 1'b1;
                    complete = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                    if (timeout) begin
                        ps_d    = StTrap;
                        cause_d = CauseTimeout;
                    end
                end
            end
            StWb: begin
                RF_WE    = 1'b1;
                PC_WE    = 1'b1;
                complete = 1'b1;
            end
            StIntr: begin
                intr_taken = 1'b1;
                PC_WE      = 1'b1;
                ps_d       = StFetch;
            end
            StTrap: begin
                trap_taken = 1'b1;
                PC_WE      = 1'b1;
                trap_cause = cause_q;
                ps_d       = StFetch;
            end
            default: ps_d = StInit;
        endcase

        // An interrupt arriving with MRET waits for the next completion.
        if (complete) begin
            ps_d = (INTR_EN && intr && mie && !mret_exec) ? StIntr : StFetch;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            ps_q    <= StInit;
            cause_q <= CauseNone;
        end else begin
            ps_q    <= ps_d;
            cause_q <= cause_d;
        end
    end

    assign state = ps_q;

endmodule

// File: tb/tb_otter_cu_fsm_mc.sv
// Bench for otter_cu_fsm_mc: per-instruction expected cycle sequences built from the
// instruction's class and ready delays, then replayed against the DUT cycle by cycle.
module tb_otter_cu_fsm_mc;

    localparam int MW = 15;
    localparam int S_INIT = 0, S_FETCH = 1, S_EXEC = 2, S_LDW = 3;
    localparam int S_STW = 4, S_WB = 5, S_INTR = 6, S_TRAP = 7;
    localparam int C_ALU = 0, C_BR = 1, C_LD = 2, C_ST = 3, C_MRET = 4, C_CSR = 5, C_ILL = 6;

    logic clk = 1'b0;
    logic RST, intr, mie, mem_rdy1, mem_rdy2;
    logic [6:0] opcode;
    logic [2:0] func3;

    logic PC_WE, RF_WE, memRDEN1, memRDEN2, memWE2, csr_WE, reset;
    logic intr_taken, mret_exec, trap_taken;
    logic [1:0] trap_cause;
    logic [2:0] state;

    logic PC_WE_nt, RF_WE_nt, memRDEN1_nt, memRDEN2_nt, memWE2_nt, csr_WE_nt, reset_nt;
    logic intr_taken_nt, mret_exec_nt, trap_taken_nt;
    logic [1:0] trap_cause_nt;
    logic [2:0] state_nt;

    otter_cu_fsm_mc dut (
        .clk(clk), .RST(RST), .intr(intr), .mie(mie), .opcode(opcode), .func3(func3),
        .mem_rdy1(mem_rdy1), .mem_rdy2(mem_rdy2), .PC_WE(PC_WE), .RF_WE(RF_WE),
        .memRDEN1(memRDEN1), .memRDEN2(memRDEN2), .memWE2(memWE2), .csr_WE(csr_WE),
        .reset(reset), .intr_taken(intr_taken), .mret_exec(mret_exec),
        .trap_taken(trap_taken), .trap_cause(trap_cause), .state(state)
    );

    otter_cu_fsm_mc #(.TRAP_ILLEGAL(1'b0)) dut_nt (
        .clk(clk), .RST(RST), .intr(intr), .mie(mie), .opcode(opcode), .func3(func3),
        .mem_rdy1(mem_rdy1), .mem_rdy2(mem_rdy2), .PC_WE(PC_WE_nt), .RF_WE(RF_WE_nt),
        .memRDEN1(memRDEN1_nt), .memRDEN2(memRDEN2_nt), .memWE2(memWE2_nt),
        .csr_WE(csr_WE_nt), .reset(reset_nt), .intr_taken(intr_taken_nt),
        .mret_exec(mret_exec_nt), .trap_taken(trap_taken_nt), .trap_cause(trap_cause_nt),
        .state(state_nt)
    );

    always #5 clk = ~clk;

    logic [11:0] obs, obs_nt;
    assign obs = {PC_WE, RF_WE, memRDEN1, memRDEN2, memWE2, csr_WE, reset, intr_taken,
                  mret_exec, trap_taken, trap_cause};
    assign obs_nt = {PC_WE_nt, RF_WE_nt, memRDEN1_nt, memRDEN2_nt, memWE2_nt, csr_WE_nt,
                     reset_nt, intr_taken_nt, mret_exec_nt, trap_taken_nt, trap_cause_nt};

    // Output-vector field masks
    localparam logic [11:0] O_PC = 12'h800, O_RF = 12'h400, O_RD1 = 12'h200, O_RD2 = 12'h100;
    localparam logic [11:0] O_WE2 = 12'h080, O_CSR = 12'h040, O_RST = 12'h020, O_IT = 12'h010;
    localparam logic [11:0] O_MR = 12'h008, O_TT = 12'h004;

    typedef struct {
        int          st;
        logic [11:0] outs;
        logic        r1, r2;
        bit          c1, c2;
    } cyc_t;

    cyc_t q[$];
    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic push(input int st, input logic [11:0] o, input logic r1, input logic r2,
                        input bit c1, input bit c2);
        cyc_t c;
        c.st = st; c.outs = o; c.r1 = r1; c.r2 = r2; c.c1 = c1; c.c2 = c2;
        q.push_back(c);
    endtask

    function automatic bit is_legal(input logic [6:0] op);
        return op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
    endfunction

    // Queue the expected cycles of one instruction; starts in FETCH, ends before next FETCH.
    task automatic build(input int cls, input int df, input int dm, input bit irq_go);
        bit fetched = 1'b0;
        bit done = 1'b0;
        for (int k = 0; k < MW && !fetched && !done; k++) begin
            if (k == df) begin
                push(S_FETCH, O_RD1, 1'b1, 1'b0, 1'b1, 1'b0);
                fetched = 1'b1;
            end else begin
                push(S_FETCH, O_RD1, 1'b0, 1'b0, 1'b1, 1'b0);
                if (k == MW - 1) begin
                    push(S_TRAP, O_PC | O_TT | 12'd2, 1'b0, 1'b0, 1'b0, 1'b0);
                    done = 1'b1;
                end
            end
        end
        if (!fetched) return;
        case (cls)
            C_ALU:  push(S_EXEC, O_PC | O_RF, 1'b0, 1'b0, 1'b0, 1'b0);
            C_BR:   push(S_EXEC, O_PC, 1'b0, 1'b0, 1'b0, 1'b0);
            C_MRET: push(S_EXEC, O_PC | O_MR, 1'b0, 1'b0, 1'b0, 1'b0);
            C_CSR:  push(S_EXEC, O_PC | O_RF | O_CSR, 1'b0, 1'b0, 1'b0, 1'b0);
            C_ILL: begin
                push(S_EXEC, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
                push(S_TRAP, O_PC | O_TT | 12'd1, 1'b0, 1'b0, 1'b0, 1'b0);
                return;
            end
            C_LD: begin
                push(S_EXEC, O_RD2, 1'b0, 1'b0, 1'b0, 1'b0);
                for (int i = 1; i < MW; i++) begin
                    if (i == dm) begin
                        push(S_LDW, O_RD2, 1'b0, 1'b1, 1'b0, 1'b1);
                        push(S_WB, O_PC | O_RF, 1'b0, 1'b0, 1'b0, 1'b0);
                        break;
                    end
                    push(S_LDW, O_RD2, 1'b0, 1'b0, 1'b0, 1'b1);
                    if (i == MW - 1) begin
                        push(S_TRAP, O_PC | O_TT | 12'd2, 1'b0, 1'b0, 1'b0, 1'b0);
                        return;
                    end
                end
            end
            default: begin
                if (dm == 0) begin
                    push(S_EXEC, O_WE2 | O_PC, 1'b0, 1'b1, 1'b0, 1'b1);
                end else begin
                    push(S_EXEC, O_WE2, 1'b0, 1'b0, 1'b0, 1'b1);
                    for (int i = 1; i < MW; i++) begin
                        if (i == dm) begin
                            push(S_STW, O_WE2 | O_PC, 1'b0, 1'b1, 1'b0, 1'b1);
                            break;
                        end
                        push(S_STW, O_WE2, 1'b0, 1'b0, 1'b0, 1'b1);
                        if (i == MW - 1) begin
                            push(S_TRAP, O_PC | O_TT | 12'd2, 1'b0, 1'b0, 1'b0, 1'b0);
                            return;
                        end
                    end
                end
            end
        endcase
        if (irq_go && cls != C_MRET) push(S_INTR, O_PC | O_IT, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Replay the queue; instruction-level inputs change at the first cycle's negedge.
    task automatic run(input string tag, input logic [6:0] op, input logic [2:0] f3,
                       input bit irq, input bit ie);
        int n = 0;
        while (q.size() > 0) begin
            cyc_t c;
            c = q.pop_front();
            @(negedge clk);
            if (n == 0) begin
                opcode = op; func3 = f3; intr = irq; mie = ie;
            end
            mem_rdy1 = c.c1 ? c.r1 : 1'($urandom_range(0, 1));
            mem_rdy2 = c.c2 ? c.r2 : 1'($urandom_range(0, 1));
            #1;
            chk($sformatf("%s_c%0d_state", tag, n), 32'(state), 32'(c.st));
            chk($sformatf("%s_c%0d_outs", tag, n), 32'(obs), 32'(c.outs));
            n++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        RST = 1'b1; mem_rdy1 = 1'b0; mem_rdy2 = 1'b0; intr = 1'b0; mie = 1'b0;
        @(negedge clk);
        @(negedge clk);
        RST = 1'b0;
        #1;
        chk("reset_state", 32'(state), S_INIT);
        chk("reset_outs", 32'(obs), 32'(O_RST));
        chk("reset_state_nt", 32'(state_nt), S_INIT);
    endtask

    function automatic logic [6:0] pick_op(input int cls, output logic [2:0] f3);
        logic [6:0] alu_ops [6];
        logic [6:0] op;
        alu_ops = '{7'h13, 7'h33, 7'h37, 7'h17, 7'h6F, 7'h67};
        f3 = 3'($urandom_range(0, 7));
        case (cls)
            C_ALU:  op = alu_ops[$urandom_range(0, 5)];
            C_BR:   op = 7'h63;
            C_LD:   op = 7'h03;
            C_ST:   op = 7'h23;
            C_MRET: begin op = 7'h73; f3 = 3'b000; end
            C_CSR:  begin op = 7'h73; f3 = 3'($urandom_range(1, 7)); end
            default: begin
                op = 7'($urandom_range(0, 127));
                while (is_legal(op)) op = 7'($urandom_range(0, 127));
            end
        endcase
        return op;
    endfunction

    initial begin
        RST = 1'b1; intr = 1'b0; mie = 1'b0; mem_rdy1 = 1'b0; mem_rdy2 = 1'b0;
        opcode = 7'h13; func3 = 3'b000;

        // ADDI with instant ready
        do_reset();
        build(C_ALU, 0, 0, 1'b0);   run("addi", 7'h13, 3'b000, 1'b0, 1'b0);
        // LW, data ready after 3 cycles
        build(C_LD, 0, 3, 1'b0);    run("lw", 7'h03, 3'b010, 1'b0, 1'b0);
        // SW, data never ready -> timeout trap
        build(C_ST, 0, 99, 1'b0);   run("sw_to", 7'h23, 3'b010, 1'b0, 1'b0);
        // fetch timeout
        build(C_ALU, 99, 0, 1'b0);  run("fetch_to", 7'h13, 3'b000, 1'b0, 1'b0);
        // illegal opcode
        build(C_ILL, 0, 0, 1'b0);   run("ill", 7'h7F, 3'b000, 1'b0, 1'b0);
        // interrupts: taken, masked, deferred past MRET
        build(C_ALU, 1, 0, 1'b1);   run("add_irq", 7'h33, 3'b000, 1'b1, 1'b1);
        build(C_ALU, 0, 0, 1'b0);   run("add_mask", 7'h33, 3'b000, 1'b1, 1'b0);
        build(C_MRET, 0, 0, 1'b1);  run("mret_irq", 7'h73, 3'b000, 1'b1, 1'b1);
        build(C_ALU, 0, 0, 1'b1);   run("post_mret", 7'h13, 3'b000, 1'b1, 1'b1);
        build(C_ILL, 0, 0, 1'b1);   run("ill_irq", 7'h7F, 3'b000, 1'b1, 1'b1);

        // TRAP_ILLEGAL=0 instance executes an unknown opcode as a NOP
        do_reset();
        build(C_ALU, 0, 0, 1'b0);
        void'(q.pop_back());
        run("nt_fetch", 7'h7F, 3'b000, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("nt_exec_state", 32'(state_nt), S_EXEC);
        chk("nt_exec_outs", 32'(obs_nt), 32'(O_PC));
        chk("tr_exec_outs", 32'(obs), 32'h0);
        @(negedge clk);
        #1;
        chk("nt_next_state", 32'(state_nt), S_FETCH);
        chk("tr_next_state", 32'(state), S_TRAP);
        chk("tr_next_outs", 32'(obs), 32'(O_PC | O_TT | 12'd1));

        // reset while waiting on a store
        do_reset();
        build(C_ST, 0, 4, 1'b0);
        while (q.size() > 4) void'(q.pop_back());
        run("st_rst", 7'h23, 3'b000, 1'b0, 1'b0);
        @(negedge clk);
        RST = 1'b1; mem_rdy2 = 1'b0;
        #1;
        chk("st_rst_pre", 32'(state), S_STW);
        @(negedge clk);
        RST = 1'b0;
        #1;
        chk("st_rst_state", 32'(state), S_INIT);
        chk("st_rst_outs", 32'(obs), 32'(O_RST));
        chk("st_rst_we2", 32'(memWE2), 32'h0);

        // randomized instruction stream
        for (int t = 0; t < 80; t++) begin
            int cls, df, dm;
            bit irq, ie;
            logic [6:0] op;
            logic [2:0] f3;
            cls = $urandom_range(0, 6);
            df = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 17) : $urandom_range(0, 3);
            dm = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 17) : $urandom_range(0, 4);
            if (cls == C_LD && dm == 0) dm = 1;
            irq = 1'($urandom_range(0, 1));
            ie = 1'($urandom_range(0, 1));
            op = pick_op(cls, f3);
            build(cls, df, dm, irq && ie);
            run($sformatf("rnd%0d", t), op, f3, irq, ie);
        end
        // the stream must end back in FETCH
        @(negedge clk);
        #1;
        chk("rnd_end_state", 32'(state), S_FETCH);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
